// File: rtl/instruction_cache.sv
// ============================================================================
//  Module   : instruction_cache
//  Brief    : Read-only direct-mapped instruction cache. It has 8 lines of
//             16 bytes, a zero-cycle hit path, a block fill from instruction
//             memory, and saturating hit/miss statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_cache #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      PC,
  output logic [31:0]      INSTRUCTION,
  output logic             BUSYWAIT,
  output logic             MEM_READ,
  output logic [5:0]       MEM_ADDRESS,
  input  logic [127:0]     MEM_READDATA,
  input  logic             MEM_BUSYWAIT,
  output logic [CNT_W-1:0] HIT_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  localparam int              LINES   = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Address fields. Byte offset and the upper PC bits play no part in lookup.
  logic [2:0] pc_tag;
  logic [2:0] pc_index;
  logic [1:0] pc_word;
  logic       unused_pc_bits;

  assign pc_tag         = PC[9:7];
  assign pc_index       = PC[6:4];
  assign pc_word        = PC[3:2];
  assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

  // Line storage. Only the valid bits are reset; tags and data are don't-care
  // until their valid bit is set by a fill.
  logic [LINES-1:0] valid_q;
  logic [2:0]       tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  state_t     state_q, state_d;
  logic [5:0] miss_addr_q, miss_addr_d;   // {tag, index} of the line being filled
  logic       first_fetch_q;              // high in the first FETCH cycle only
  logic       after_update_q;             // high in the first IDLE cycle after UPDATE
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic         hit;
  logic         fill_en;
  logic [127:0] sel_line;
  logic [31:0]  sel_word;

  // Lookup: a hit is only possible while the FSM sits in IDLE.
  always_comb begin
    sel_line = data_q[pc_index];
    sel_word = sel_line[{pc_word, 5'b00000} +: 32];
    hit      = (state_q == IDLE) && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  end

  // Next-state logic. The memory handshake is ignored in the first FETCH cycle
  // so a stale "ready" from a previous read cannot complete a new fill.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d     = FETCH;
          miss_addr_d = {pc_tag, pc_index};
        end
      end
      FETCH: begin
        if (!first_fetch_q && !MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU and memory-side outputs; everything is forced quiet while RESET is high.
  always_comb begin
    BUSYWAIT    = !RESET && !hit;
    MEM_READ    = !RESET && (state_q == FETCH);
    MEM_ADDRESS = MEM_READ ? miss_addr_q : 6'h00;
    INSTRUCTION = (!RESET && hit) ? sel_word : 32'h0000_0000;
    HIT_COUNT   = hit_cnt_q;
    MISS_COUNT  = miss_cnt_q;
  end

  // Control state, valid bits and saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      miss_addr_q    <= 6'h00;
      first_fetch_q  <= 1'b0;
      after_update_q <= 1'b0;
      valid_q        <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      miss_addr_q    <= miss_addr_d;
      first_fetch_q  <= (state_q == IDLE) && (state_d == FETCH);
      after_update_q <= (state_q == UPDATE);
      if (fill_en) begin
        valid_q[miss_addr_q[2:0]] <= 1'b1;
      end
      if ((state_q == IDLE) && (state_d == FETCH) && (miss_cnt_q != CNT_MAX)) begin
        miss_cnt_q <= miss_cnt_q + CNT_ONE;
      end
      // The re-presented PC right after a fill is the tail of the miss, not a new hit.
      if (hit && !after_update_q && (hit_cnt_q != CNT_MAX)) begin
        hit_cnt_q <= hit_cnt_q + CNT_ONE;
      end
    end
  end

  // Tag and data arrays: written by a completed fill, never by reset.
  always_ff @(posedge CLK) begin
    if (fill_en && !RESET) begin
      tag_q[miss_addr_q[2:0]]  <= miss_addr_q[5:3];
      data_q[miss_addr_q[2:0]] <= MEM_READDATA;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_cache.sv
// ============================================================================
//  Module   : tb_instruction_cache
//  Brief    : Directed self-checking bench for instruction_cache with a
//             simple latency-programmable instruction memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic [3:0]   HIT_COUNT;
  logic [3:0]   MISS_COUNT;

  int checks;
  int failures;
  int lat;
  int mem_cnt;

  instruction_cache #(.CNT_W(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: word n of block a is 32'hD000_{a,n}, except block 0 word 0.
  function automatic logic [31:0] mword(input logic [5:0] a, input logic [1:0] n);
    if (a == 6'h00 && n == 2'd0) return 32'hAABB_0011;
    return {16'hD000, 2'b00, a, 6'b000000, n};
  endfunction

  assign MEM_READDATA = {mword(MEM_ADDRESS, 2'd3), mword(MEM_ADDRESS, 2'd2),
                         mword(MEM_ADDRESS, 2'd1), mword(MEM_ADDRESS, 2'd0)};
  // Memory is ready once MEM_READ has been held for lat-1 earlier cycles.
  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < lat - 1);

  // Track how long the current read request has been held.
  always @(posedge CLK) begin
    mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Count BUSYWAIT cycles from the current cycle until the CPU is released.
  task automatic run_miss(output int n, output logic [5:0] addr);
    n    = 0;
    addr = 6'h00;
    while (n < 30) begin
      #1;
      if (!BUSYWAIT) break;
      if (MEM_READ) addr = MEM_ADDRESS;
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n;
    logic [5:0] a;
    int         ok;
    int         errs;

    checks   = 0;
    failures = 0;
    lat      = 3;
    mem_cnt  = 0;
    RESET    = 1'b1;
    PC       = 32'h0;

    // Reset behaviour
    @(negedge CLK); #1;
    check("rst_busywait", BUSYWAIT, 0);
    check("rst_memread", MEM_READ, 0);
    check("rst_memaddr", MEM_ADDRESS, 0);
    check("rst_instr", INSTRUCTION, 0);
    check("rst_hits", HIT_COUNT, 0);
    check("rst_misses", MISS_COUNT, 0);

    // Cold miss, latency 3
    @(negedge CLK);
    RESET = 1'b0;
    PC    = 32'h000;
    run_miss(n, a);
    check("cold_busy_cycles", n, 5);
    check("cold_memaddr", a, 6'h00);
    check("cold_instr", INSTRUCTION, 32'hAABB_0011);
    check("cold_misses", MISS_COUNT, 1);
    check("cold_hits", HIT_COUNT, 0);

    // Sequential hits to words 1..3
    @(negedge CLK); PC = 32'h004; #1;
    check("seq_w1", INSTRUCTION, 32'hD000_0001);
    check("seq_w1_busy", BUSYWAIT, 0);
    check("seq_w1_memread", MEM_READ, 0);
    @(negedge CLK); PC = 32'h008; #1;
    check("seq_w2", INSTRUCTION, 32'hD000_0002);
    check("seq_w2_busy", BUSYWAIT, 0);
    @(negedge CLK); PC = 32'h00C; #1;
    check("seq_w3", INSTRUCTION, 32'hD000_0003);
    check("seq_w3_memread", MEM_READ, 0);

    // Conflict misses on index 1
    @(negedge CLK); PC = 32'h010; #1;
    check("seq_hits", HIT_COUNT, 3);
    run_miss(n, a);
    check("cf_a_memaddr", a, 6'h01);
    check("cf_a_instr", INSTRUCTION, 32'hD000_0100);
    lat = 1;
    @(negedge CLK); PC = 32'h090;
    run_miss(n, a);
    check("cf_b_min_penalty", n, 4);
    check("cf_b_memaddr", a, 6'h09);
    check("cf_b_instr", INSTRUCTION, 32'hD000_0900);
    check("cf_b_misses", MISS_COUNT, 3);
    lat = 3;
    @(negedge CLK); PC = 32'h010;
    run_miss(n, a);
    check("cf_c_memaddr", a, 6'h01);
    check("cf_c_misses", MISS_COUNT, 4);
    check("cf_c_hits", HIT_COUNT, 3);

    // Reset in the middle of a fill
    @(negedge CLK); PC = 32'h040; #1;
    check("mf_idle_miss", BUSYWAIT, 1);
    @(negedge CLK); #1;
    check("mf_fetch_memread", MEM_READ, 1);
    RESET = 1'b1; #1;
    check("mf_rst_memread", MEM_READ, 0);
    check("mf_rst_busy", BUSYWAIT, 0);
    @(negedge CLK); RESET = 1'b0; #1;
    check("mf_hits_cleared", HIT_COUNT, 0);
    check("mf_misses_cleared", MISS_COUNT, 0);
    run_miss(n, a);
    check("mf_reaccess_cycles", n, 5);
    check("mf_reaccess_addr", a, 6'h04);
    check("mf_misses", MISS_COUNT, 1);

    // PC disturbance while fetching line 2
    @(negedge CLK); PC = 32'h020; #1;
    check("pd_idle_miss", BUSYWAIT, 1);
    @(negedge CLK); PC = 32'h3F0; #1;
    check("pd_fetch_addr", MEM_ADDRESS, 6'h02);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (!MEM_READ) break;
      if (MEM_ADDRESS !== 6'h02) ok = 0;
    end
    check("pd_addr_stable", ok, 1);
    check("pd_update_busy", BUSYWAIT, 1);
    @(negedge CLK); #1;
    check("pd_new_pc_miss", BUSYWAIT, 1);
    check("pd_new_pc_idle", MEM_READ, 0);
    @(negedge CLK); #1;
    check("pd_new_fetch_addr", MEM_ADDRESS, 6'h3F);
    run_miss(n, a);
    check("pd_new_instr", INSTRUCTION, 32'hD000_3F00);

    // Saturation: 20 hits alternating lines 2 and 7
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      PC = (i % 2 == 0) ? 32'h020 : 32'h3F0;
      #1;
      if (i == 14) check("sat_pre", HIT_COUNT, 14);
      if (BUSYWAIT !== 1'b0) errs++;
      if (INSTRUCTION !== ((i % 2 == 0) ? 32'hD000_0200 : 32'hD000_3F00)) errs++;
    end
    check("sat_hit_data", errs, 0);
    @(negedge CLK); PC = 32'h000; #1;
    check("sat_hits", HIT_COUNT, 4'hF);
    check("sat_misses", MISS_COUNT, 3);
    check("post_reset_line0_miss", BUSYWAIT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
